// File: rtl/rca_word_sequencer_if.sv
// Word-stream bus between an operand source and the RCA word sequencer.
// The master drives operand words and accepts sum words; the slave is the sequencer.
interface rca_word_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int IDXW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_first;
    logic             in_last;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_last;
    logic             out_cout;
    logic             out_ovf;
    logic [IDXW-1:0]  out_idx;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_idx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_idx
    );
endinterface

// File: rtl/rca_word_sequencer.sv
// Multi-word adder front-end: streams LS-word-first operand pairs through one
// ripple-carry adder, chaining carry between beats, with registered 1-cycle output.

module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rca_fa_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end
endmodule

module rca_word_sequencer #(
    parameter int WIDTH = 4,
    parameter int IDXW  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rca_word_sequencer_if.slave  bus,
    output logic                 err
);
    typedef enum logic {IDLE, MID} state_t;

    localparam logic [IDXW-1:0] IDX_MAX = '1;

    state_t           state_q, state_d;
    logic             carry_q;
    logic             xfer;
    logic             treat_first;
    logic             proto_err;
    logic             c0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic [IDXW-1:0]  idx_d;
    logic             ovf_d;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;

    rca #(.WIDTH(WIDTH)) u_rca (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .cin  (c0),
        .s    (s),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A misplaced first flag (or a missing one) restarts the operand rather than
    // chaining a stale carry into it.
    always_comb begin
        state_d     = state_q;
        treat_first = bus.in_first || (state_q == IDLE);
        proto_err   = (state_q == IDLE) ? !bus.in_first : bus.in_first;
        c0          = treat_first ? bus.in_cin : carry_q;
        idx_d       = '0;
        if (!treat_first)
            idx_d = (bus.out_idx == IDX_MAX) ? IDX_MAX : bus.out_idx + 1'b1;
        ovf_d       = bus.in_last & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1] ^ s[WIDTH-1] ^ cout);
        if (xfer)
            state_d = bus.in_last ? IDLE : MID;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_idx   <= '0;
            carry_q       <= 1'b0;
            err           <= 1'b0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= s;
            bus.out_last  <= bus.in_last;
            bus.out_cout  <= cout;
            bus.out_ovf   <= ovf_d;
            bus.out_idx   <= idx_d;
            carry_q       <= cout;
            if (proto_err) err <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
